// File: rtl/sync_fifo_ctrl.sv
// Pointer, occupancy, flag and handshake controller for a synchronous FIFO
// built on an external dual-port RAM with registered read data.
module sync_fifo_ctrl #(
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = 4,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_wa,
    output logic [DWIDTH-1:0] ram_wd,
    output logic [AWIDTH-1:0] ram_ra,
    input  logic [DWIDTH-1:0] ram_rd
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
    localparam logic [AWIDTH:0]   FULL_CNT  = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0]   AF_CNT    = (AWIDTH + 1)'(AF_LEVEL);
    localparam logic [AWIDTH:0]   AE_CNT    = (AWIDTH + 1)'(AE_LEVEL);

    logic [AWIDTH-1:0] wr_ptr, rd_ptr;
    logic [AWIDTH-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic [AWIDTH:0]   count_nxt;
    logic              wr_acc, rd_acc;
    logic              ovf_set, unf_set;

    // Status flags decode straight from the registered count, so no
    // request input reaches a flag combinationally.
    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // A push while full is only legal because a same-cycle pop frees a slot.
    assign rd_acc = rd_en & ~empty & ~flush;
    assign wr_acc = wr_en & (~full | rd_en) & ~flush;

    assign ovf_set = wr_en & full & ~rd_en & ~flush;
    assign unf_set = rd_en & empty & ~flush;

    assign ram_we  = wr_acc & rst_n;
    assign ram_wa  = wr_ptr;
    assign ram_wd  = wr_data;
    assign ram_ra  = rd_ptr;
    assign rd_data = ram_rd;

    // Explicit wrap so non-power-of-two depths work.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (wr_acc)
            wr_ptr_nxt = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
        if (rd_acc)
            rd_ptr_nxt = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            rd_valid  <= rd_acc;
            overflow  <= overflow | ovf_set;
            underflow <= underflow | unf_set;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with a behavioural read-before-write RAM;
// expected pop data is queued at stimulus time and checked by a monitor.
module tb_sync_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, flush, wr_en, rd_en;
    logic [15:0] wr_data, rd_data, ram_wd, ram_rd;
    logic        rd_valid, full, empty, almost_full, almost_empty;
    logic [4:0]  count;
    logic        overflow, underflow, ram_we;
    logic [3:0]  ram_wa, ram_ra;

    logic [15:0] mem [16];
    logic [15:0] exp_q [$];
    int          checks = 0;
    int          failures = 0;

    sync_fifo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow), .ram_we(ram_we),
        .ram_wa(ram_wa), .ram_wd(ram_wd), .ram_ra(ram_ra), .ram_rd(ram_rd)
    );

    always #5 clk = ~clk;

    // Dual-port RAM: registered read returns the old word on a same-address write.
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_wd;
        ram_rd <= mem[ram_ra];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected: got %0h expected no valid word", rd_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    failures++;
                    $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        wr_en = 1'b1; rd_en = 1'b0; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop(input logic [15:0] e);
        exp_q.push_back(e);
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        #1;
        chk("rst_empty", empty, 1); chk("rst_count", count, 0);
        chk("rst_full", full, 0);   chk("rst_ae", almost_empty, 1);
        chk("rst_af", almost_full, 0); chk("rst_rd_valid", rd_valid, 0);
        chk("rst_errs", {overflow, underflow}, 0);
        wr_en = 1'b1;
        #1 chk("rst_ram_we", ram_we, 0);
        wr_en = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Fill and overflow
        for (int i = 1; i <= 16; i++) begin
            push(16'(i));
            if (i == 11) chk("af_at_11", almost_full, 0);
            if (i == 12) chk("af_at_12", almost_full, 1);
        end
        chk("fill_count", count, 16); chk("fill_full", full, 1);
        wr_en = 1'b1; wr_data = 16'h00FF;
        #1 chk("ovf_ram_we", ram_we, 0);
        tick(); wr_en = 1'b0;
        chk("ovf_flag", overflow, 1); chk("ovf_count", count, 16);

        // Drain order, then underflow
        for (int i = 1; i <= 16; i++) pop(16'(i));
        chk("drain_empty", empty, 1);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("unf_flag", underflow, 1); chk("unf_rd_valid", rd_valid, 0);
        chk("ovf_sticky", overflow, 1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_errs", {overflow, underflow}, 0);

        // Wrap-around
        for (int i = 1; i <= 10; i++) push(16'h0100 + 16'(i));
        chk("wrap_cnt10a", count, 10);
        for (int i = 1; i <= 10; i++) pop(16'h0100 + 16'(i));
        chk("wrap_cnt0", count, 0);
        for (int i = 1; i <= 10; i++) push(16'h0200 + 16'(i));
        chk("wrap_cnt10b", count, 10);
        for (int i = 1; i <= 10; i++) pop(16'h0200 + 16'(i));
        chk("wrap_drained", empty, 1);

        // Simultaneous push and pop while full
        for (int i = 1; i <= 16; i++) push(16'h0300 + 16'(i));
        exp_q.push_back(16'h0301);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'hAAAA;
        tick(); wr_en = 1'b0; rd_en = 1'b0;
        chk("sim_full_count", count, 16); chk("sim_full_ovf", overflow, 0);
        for (int i = 2; i <= 16; i++) pop(16'h0300 + 16'(i));
        pop(16'hAAAA);
        chk("sim_full_drained", empty, 1);

        // Simultaneous push and pop while empty
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'h0BEE;
        tick(); wr_en = 1'b0; rd_en = 1'b0;
        chk("sim_empty_count", count, 1); chk("sim_empty_unf", underflow, 1);
        chk("sim_empty_rv", rd_valid, 0);
        pop(16'h0BEE);

        // Flush with a pop accepted on the prior edge
        for (int i = 1; i <= 6; i++) push(16'h0400 + 16'(i));
        pop(16'h0401);
        chk("pre_flush_count", count, 5); chk("pre_flush_rv", rd_valid, 1);
        chk("pre_flush_unf", underflow, 1);
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'h0DEF;
        tick(); flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        chk("flush_count", count, 0); chk("flush_empty", empty, 1);
        chk("flush_rv", rd_valid, 0); chk("flush_unf", underflow, 0);

        // Asynchronous reset mid-stream
        for (int i = 1; i <= 3; i++) push(16'h0500 + 16'(i));
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("pre_rst_rv", rd_valid, 1);
        wr_en = 1'b1; wr_data = 16'h0EEE;
        #1 rst_n = 1'b0;
        #1;
        chk("async_empty", empty, 1); chk("async_count", count, 0);
        chk("async_rv", rd_valid, 0); chk("async_ram_we", ram_we, 0);
        tick(); wr_en = 1'b0; rst_n = 1'b1;
        tick();
        push(16'h0777);
        chk("post_rst_count", count, 1);
        pop(16'h0777);
        tick(); tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
